// File: rtl/fpga_pkg.sv
// Shared definitions for the FPGA test harness: data word width and the
// receiver state enumeration.
package fpga_pkg;

    localparam int unsigned MemoryElementWidth = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
    } state_t;

    // Index width that stays legal (>= 1 bit) for single-entry tables.
    function automatic int unsigned index_width(input int unsigned entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/out_channel_fifo.sv
// Receive buffer for out_channel_receiver: power-of-two circular FIFO with
// show-ahead read data and occupancy-derived full/empty flags.
module out_channel_fifo #(
    parameter int unsigned Width = 12,
    parameter int unsigned Depth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] data
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned OccWidth = $clog2(Depth + 1);
    localparam logic [OccWidth-1:0] DepthOcc = OccWidth'(Depth);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wptr_q;
    logic [PtrWidth-1:0] rptr_q;
    logic [OccWidth-1:0] occ_q;
    logic                do_push;
    logic                do_pop;

    assign full    = (occ_q == DepthOcc);
    assign empty   = (occ_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign data    = mem[rptr_q];

    // Pointers are exactly log2(Depth) wide, so increments wrap for free.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PtrWidth'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PtrWidth'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + OccWidth'(1);
                2'b01:   occ_q <= occ_q - OccWidth'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/out_channel_receiver.sv
// Collects NOut out-channel words, compares them in order against a preloaded
// expected table and reports PASS/FAIL. Define OUT_CHANNEL_TIMEOUT_EN for the idle watchdog.
module out_channel_receiver #(
    parameter int unsigned MemoryElementWidth = fpga_pkg::MemoryElementWidth,
    parameter int unsigned NOut               = 3,
    parameter int unsigned FifoDepth          = 4,
    parameter int unsigned TimeoutCycles      = 64
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       expWrite,
    input  logic [fpga_pkg::index_width(NOut)-1:0]     expAddress,
    input  logic [MemoryElementWidth-1:0]              expData,
    input  logic                                       start,
    input  logic                                       outValid,
    input  logic [MemoryElementWidth-1:0]              outData,
    output logic                                       outReady,
    input  logic                                       hold,
    output logic                                       finished,
    output logic                                       success,
    output logic [$clog2(NOut+1)-1:0]                  count,
    output logic [fpga_pkg::index_width(NOut)-1:0]     mismatchIndex,
    output logic                                       timedOut
);

    import fpga_pkg::*;

    localparam int unsigned IdxWidth   = index_width(NOut);
    localparam int unsigned CountWidth = $clog2(NOut + 1);
    localparam logic [CountWidth-1:0] NOutCount = CountWidth'(NOut);

    state_t                          state_q, state_d;
    logic [CountWidth-1:0]           count_q, count_d;
    logic [CountWidth-1:0]           accepted_q, accepted_d;
    logic [IdxWidth-1:0]             mismatch_q, mismatch_d;
    logic                            finished_q, success_q;
    logic [MemoryElementWidth-1:0]   expTable [NOut];
    logic                            push, pop;
    logic                            fifoFull, fifoEmpty;
    logic [MemoryElementWidth-1:0]   fifoData;
    logic                            match;

    // The expected table deliberately survives reset so a rerun needs no reload.
    always_ff @(posedge clock) begin
        if (state_q == IDLE && expWrite) begin
            expTable[expAddress] <= expData;
        end
    end

    assign outReady = (state_q == RUN) && !fifoFull && (accepted_q < NOutCount);
    assign push     = outValid && outReady;
    assign pop      = (state_q == RUN) && !fifoEmpty && !hold;
    assign match    = (fifoData == expTable[count_q[IdxWidth-1:0]]);

    out_channel_fifo #(
        .Width (MemoryElementWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (outData),
        .pop   (pop),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .data  (fifoData)
    );

`ifdef OUT_CHANNEL_TIMEOUT_EN
    localparam int unsigned IdleWidth = $clog2(TimeoutCycles + 1);
    localparam logic [IdleWidth-1:0] IdleLast = IdleWidth'(TimeoutCycles - 1);

    logic [IdleWidth-1:0] idle_q, idle_d;
    logic                 timedOut_q, timedOut_d;
    logic                 idleExpired;

    assign idleExpired = (state_q == RUN) && !push && !pop && (idle_q == IdleLast);
    assign idle_d      = ((state_q == RUN) && !push && !pop) ? idle_q + IdleWidth'(1) : '0;
    assign timedOut    = timedOut_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_q     <= '0;
            timedOut_q <= 1'b0;
        end else begin
            idle_q     <= idle_d;
            timedOut_q <= timedOut_d;
        end
    end
`else
    logic idleExpired;

    assign idleExpired = 1'b0;
    assign timedOut    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mismatch_d = mismatch_q;
        accepted_d = accepted_q + (push ? CountWidth'(1) : CountWidth'(0));
`ifdef OUT_CHANNEL_TIMEOUT_EN
        timedOut_d = timedOut_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pop) begin
                    if (match) begin
                        count_d = count_q + CountWidth'(1);
                        if (count_d == NOutCount) begin
                            state_d = PASS;
                        end
                    end else begin
                        state_d    = FAIL;
                        mismatch_d = count_q[IdxWidth-1:0];
                    end
                end else if (idleExpired) begin
                    state_d    = FAIL;
                    mismatch_d = count_q[IdxWidth-1:0];
`ifdef OUT_CHANNEL_TIMEOUT_EN
                    timedOut_d = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            accepted_q <= '0;
            mismatch_q <= '0;
            finished_q <= 1'b0;
            success_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            accepted_q <= accepted_d;
            mismatch_q <= mismatch_d;
            finished_q <= (state_d == PASS) || (state_d == FAIL);
            success_q  <= (state_d == PASS);
        end
    end

    assign finished      = finished_q;
    assign success       = success_q;
    assign count         = count_q;
    assign mismatchIndex = mismatch_q;

endmodule

// File: tb/tb_out_channel_receiver.sv
// Directed self-checking bench: instance a (NOut=3, TimeoutCycles=16) and
// instance b (NOut=6) for the FIFO back-pressure scenario.
module tb_out_channel_receiver;

    logic        clock = 1'b0;
    int          tests = 0;
    int          failures = 0;

    // Instance a
    logic        reset = 1'b1;
    logic        expWrite = 1'b0;
    logic [1:0]  expAddress = '0;
    logic [11:0] expData = '0;
    logic        start = 1'b0;
    logic        outValid = 1'b0;
    logic [11:0] outData = '0;
    logic        outReady;
    logic        hold = 1'b0;
    logic        finished, success, timedOut;
    logic [1:0]  count, mismatchIndex;

    // Instance b
    logic        b_reset = 1'b1;
    logic        b_expWrite = 1'b0;
    logic [2:0]  b_expAddress = '0;
    logic [11:0] b_expData = '0;
    logic        b_start = 1'b0;
    logic        b_outValid = 1'b0;
    logic [11:0] b_outData = '0;
    logic        b_outReady;
    logic        b_hold = 1'b0;
    logic        b_finished, b_success, b_timedOut;
    logic [2:0]  b_count, b_mismatchIndex;

    always #5 clock = ~clock;

    out_channel_receiver #(
        .MemoryElementWidth (12),
        .NOut               (3),
        .FifoDepth          (4),
        .TimeoutCycles      (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .expWrite      (expWrite),
        .expAddress    (expAddress),
        .expData       (expData),
        .start         (start),
        .outValid      (outValid),
        .outData       (outData),
        .outReady      (outReady),
        .hold          (hold),
        .finished      (finished),
        .success       (success),
        .count         (count),
        .mismatchIndex (mismatchIndex),
        .timedOut      (timedOut)
    );

    out_channel_receiver #(
        .MemoryElementWidth (12),
        .NOut               (6),
        .FifoDepth          (4),
        .TimeoutCycles      (64)
    ) dut_b (
        .clock         (clock),
        .reset         (b_reset),
        .expWrite      (b_expWrite),
        .expAddress    (b_expAddress),
        .expData       (b_expData),
        .start         (b_start),
        .outValid      (b_outValid),
        .outData       (b_outData),
        .outReady      (b_outReady),
        .hold          (b_hold),
        .finished      (b_finished),
        .success       (b_success),
        .count         (b_count),
        .mismatchIndex (b_mismatchIndex),
        .timedOut      (b_timedOut)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        outValid = 1'b0;
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic load(input logic [1:0] addr, input logic [11:0] value);
        @(negedge clock);
        expWrite = 1'b1;
        expAddress = addr;
        expData = value;
        @(negedge clock);
        expWrite = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Offers one word for one cycle; acc reports whether it was taken.
    task automatic send(input logic [11:0] value, output logic acc);
        @(negedge clock);
        outValid = 1'b1;
        outData = value;
        acc = outReady;
        @(negedge clock);
        outValid = 1'b0;
    endtask

    task automatic wait_finished(input string tag, input int budget);
        int n = 0;
        while (finished !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, finished, 1);
    endtask

    initial begin
        logic acc;
        int   nacc;
        logic hs;

        // Reset state of instance a
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_finished", finished, 0);
        check("rst_success", success, 0);
        check("rst_count", count, 0);
        check("rst_mismatch", mismatchIndex, 0);
        check("rst_timedout", timedOut, 0);
        check("rst_ready", outReady, 0);

        load(2'd0, 12'd1);
        load(2'd1, 12'd2);
        load(2'd2, 12'd3);

        // Back-to-back 1,2,3
        do_start();
        check("t1_ready_run", outReady, 1);
        @(negedge clock);
        outValid = 1'b1;
        outData = 12'd1;
        @(negedge clock);
        outData = 12'd2;
        @(negedge clock);
        outData = 12'd3;
        @(negedge clock);
        outValid = 1'b0;
        wait_finished("t1_finished", 10);
        check("t1_success", success, 1);
        check("t1_count", count, 3);
        check("t1_ready", outReady, 0);
        repeat (3) @(negedge clock);
        check("t1_sticky", finished, 1);
        check("t1_ready_after", outReady, 0);

        // Table write during RUN is ignored
        pulse_reset();
        do_start();
        @(negedge clock);
        expWrite = 1'b1;
        expAddress = 2'd0;
        expData = 12'd9;
        @(negedge clock);
        expWrite = 1'b0;
        send(12'd1, acc);
        send(12'd2, acc);
        send(12'd3, acc);
        wait_finished("t6_finished", 10);
        check("t6_success", success, 1);
        check("t6_count", count, 3);

        // Mismatch on second word
        pulse_reset();
        do_start();
        send(12'd1, acc);
        check("t2_acc1", acc, 1);
        send(12'd5, acc);
        check("t2_acc2", acc, 1);
        send(12'd3, acc);
        check("t2_acc3", acc, 0);
        check("t2_finished", finished, 1);
        check("t2_success", success, 0);
        check("t2_mismatch", mismatchIndex, 1);
        check("t2_count", count, 1);
        check("t2_ready", outReady, 0);

        // Reset after two matches, rerun without reload
        pulse_reset();
        do_start();
        send(12'd1, acc);
        send(12'd2, acc);
        @(negedge clock);
        check("t4_count_mid", count, 2);
        pulse_reset();
        check("t4_finished", finished, 0);
        check("t4_success", success, 0);
        check("t4_count", count, 0);
        check("t4_mismatch", mismatchIndex, 0);
        check("t4_timedout", timedOut, 0);
        check("t4_ready_idle", outReady, 0);
        do_start();
        send(12'd1, acc);
        send(12'd2, acc);
        send(12'd3, acc);
        wait_finished("t4_rerun_finished", 10);
        check("t4_rerun_success", success, 1);

        // Idle watchdog
        pulse_reset();
        do_start();
        send(12'd1, acc);
        @(negedge clock);
        check("t5_count", count, 1);
        repeat (15) @(negedge clock);
        check("t5_not_yet", finished, 0);
        @(negedge clock);
`ifdef OUT_CHANNEL_TIMEOUT_EN
        check("t5_finished", finished, 1);
        check("t5_timedout", timedOut, 1);
        check("t5_success", success, 0);
        check("t5_mismatch", mismatchIndex, 1);
`else
        check("t5_finished", finished, 0);
        check("t5_timedout", timedOut, 0);
        check("t5_ready", outReady, 1);
        check("t5_count_hold", count, 1);
`endif

        // Instance b: back-pressure with hold
        @(negedge clock);
        b_reset = 1'b0;
        check("b_rst_count", b_count, 0);
        check("b_rst_finished", b_finished, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            b_expWrite = 1'b1;
            b_expAddress = 3'(i);
            b_expData = 12'(10 + i);
        end
        @(negedge clock);
        b_expWrite = 1'b0;
        b_start = 1'b1;
        b_hold = 1'b1;
        @(negedge clock);
        b_start = 1'b0;
        nacc = 0;
        repeat (8) begin
            b_outValid = (nacc < 6);
            b_outData = 12'(10 + nacc);
            hs = b_outValid && b_outReady;
            @(negedge clock);
            if (hs) nacc++;
        end
        check("t3_accepted_hold", nacc, 4);
        check("t3_ready_full", b_outReady, 0);
        check("t3_count_hold", b_count, 0);
        b_hold = 1'b0;
        repeat (12) begin
            b_outValid = (nacc < 6);
            b_outData = 12'(10 + nacc);
            hs = b_outValid && b_outReady;
            @(negedge clock);
            if (hs) nacc++;
        end
        b_outValid = 1'b0;
        check("t3_accepted_all", nacc, 6);
        check("t3_finished", b_finished, 1);
        check("t3_success", b_success, 1);
        check("t3_count", b_count, 6);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
